alu_share_arbiter: RTL

Shares one ALU datapath between NUM_REQ requesters, for example the execute stage and a multi-cycle helper unit. Each requester uses a valid/ready request channel, and a round-robin grant selects one operation per cycle. The block registers the selected operation's result into a single response slot with backpressure. It sits beside the execute stage and owns the only ALU instance in that region.

---
 rtl/alu_share_arbiter_pkg.sv | 30 +++
 rtl/alu_share_arbiter_if.sv | 30 +++
 rtl/alu_share_arbiter_rr.sv | 34 +++
 rtl/alu_share_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: supported operation codes, legality check and default widths.
package alu_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_OPCODE_LENGTH = 4;
  localparam int DEF_NUM_REQ       = 2;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_LT  = 4'b1100
  } alu_op_e;

  function automatic logic is_supported_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SUB, ALU_SRA,
      ALU_EQ, ALU_LT: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters/consumer (master) and the shared ALU (slave).
interface alu_share_arbiter_if import alu_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int OPCODE_LENGTH = DEF_OPCODE_LENGTH,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb;
  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op;
  logic                             resp_valid;
  logic                             resp_ready;
  logic [ID_W-1:0]                  resp_id;
  logic [DATA_WIDTH-1:0]            resp_result;
  logic                             resp_illegal;

  modport master (
    output req_valid, req_srca, req_srcb, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_illegal
  );

  modport slave (
    input  req_valid, req_srca, req_srcb, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_illegal
  );

endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to the bottom.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // Two passes replace the modulo scan: upper segment [ptr..N-1], then wrapped [0..ptr-1].
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!grant_valid && req[j] && (j >= int'(ptr))) begin
        grant[j]    = 1'b1;
        grant_idx   = IW'(j);
        grant_valid = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!grant_valid && req[j] && (j < int'(ptr))) begin
        grant[j]    = 1'b1;
        grant_idx   = IW'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters: round-robin grant, single registered response slot.
module alu_share_arbiter import alu_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int OPCODE_LENGTH = DEF_OPCODE_LENGTH,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus,
  output logic [ID_W-1:0]      rr_ptr
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  // Handshake: a request moves on a cycle with req_valid[i] && req_ready[i]; the requester
  // holds valid/operands/op until then. The response moves on resp_valid && resp_ready and
  // all resp_* fields hold while resp_valid && !resp_ready.
  logic                     slot_free;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          gnt_idx;
  logic                     gnt_valid;
  logic                     accept;
  logic [DATA_WIDTH-1:0]    sel_a;
  logic [DATA_WIDTH-1:0]    sel_b;
  logic [OPCODE_LENGTH-1:0] sel_op;
  logic                     op_legal;
  logic [DATA_WIDTH-1:0]    alu_y;

  assign slot_free = !bus.resp_valid || bus.resp_ready;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req         (bus.req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (gnt_idx),
    .grant_valid (gnt_valid)
  );

  // Gated by reset so no requester sees an accept while the block is held in reset.
  assign bus.req_ready = (reset && slot_free) ? grant : '0;
  assign accept        = slot_free && gnt_valid;

  assign sel_a  = bus.req_srca[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b  = bus.req_srcb[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_op = bus.req_op[gnt_idx*OPCODE_LENGTH +: OPCODE_LENGTH];

  assign op_legal = is_supported_op(sel_op[3:0]) && ((sel_op >> 4) == '0);

  always_comb begin
    alu_y = '0;
    case (sel_op[3:0])
      ALU_AND: alu_y = sel_a & sel_b;
      ALU_OR:  alu_y = sel_a | sel_b;
      ALU_ADD: alu_y = sel_a + sel_b;
      ALU_XOR: alu_y = sel_a ^ sel_b;
      ALU_SLL: alu_y = sel_a << sel_b[SH_W-1:0];
      ALU_SRL: alu_y = sel_a >> sel_b[SH_W-1:0];
      ALU_SUB: alu_y = sel_a - sel_b;
      ALU_SRA: alu_y = $signed(sel_a) >>> sel_b[SH_W-1:0];
      ALU_EQ:  alu_y = DATA_WIDTH'(sel_a == sel_b);
      ALU_LT:  alu_y = DATA_WIDTH'($signed(sel_a) < $signed(sel_b));
      default: alu_y = '0;
    endcase
    if (!op_legal) alu_y = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.resp_valid   <= 1'b0;
      bus.resp_id      <= '0;
      bus.resp_result  <= '0;
      bus.resp_illegal <= 1'b0;
      rr_ptr           <= '0;
    end else if (accept) begin
      bus.resp_valid   <= 1'b1;
      bus.resp_id      <= gnt_idx;
      bus.resp_result  <= alu_y;
      bus.resp_illegal <= !op_legal;
      rr_ptr           <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (bus.resp_ready) begin
      bus.resp_valid   <= 1'b0;
    end
  end

endmodule
